syn_rx_frame: RTL

Parametrised time-sync frame receiver for slave nodes: it deserialises the sync broadcast on `data_to_slave` (UART-style 8N1, idle high, LSB first) and validates a multi-byte frame (sync byte, time word, XOR checksum). It publishes the time word with a one-cycle load strobe. It replaces the fixed single-byte `syn_rx`, generalising bit period and time-word width, and adds frame validation, error reporting and an inter-byte timeout.

---
 rtl/syn_pkg.sv | 20 ++
 rtl/syn_rx_byte.sv | 114 +++++++++++
 rtl/syn_rx_frame.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/syn_pkg.sv
// Shared types for the sync-frame receiver: byte-receiver and frame-FSM states,
// plus the default frame header value.
package syn_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        FR_HUNT,
        FR_TIME,
        FR_CHECK
    } fr_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/syn_rx_byte.sv
// 8N1 serial byte receiver: 2-FF synchroniser, falling-edge start detect,
// mid-bit sampling, one-cycle valid / framing-error pulses.
module syn_rx_byte
    import syn_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_10M,
    input  logic       rst,
    input  logic       data_to_slave,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       byte_ferr,
    output logic       idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_reg;
    logic          prev_reg;
    rx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          valid_reg, valid_next;
    logic          ferr_reg, ferr_next;

    logic line;
    logic fall;

    assign line = sync_reg[1];
    assign fall = prev_reg & ~line;

    // Synchroniser and edge history reset to the idle-high level so that
    // reset release never fabricates a falling edge on an idle line.
    always_ff @(posedge clk_10M or posedge rst) begin
        if (rst) begin
            sync_reg  <= 2'b11;
            prev_reg  <= 1'b1;
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], data_to_slave};
            prev_reg  <= line;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (fall) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_M1) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = line ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    shift_next = {line, shift_reg[7:1]};
                    idx_next   = idx_reg + 1'b1;
                    if (idx_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    valid_next = line;
                    ferr_next  = ~line;
                    state_next = RX_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_data    = shift_reg;
    assign byte_valid = valid_reg;
    assign byte_ferr  = ferr_reg;
    assign idle       = (state_reg == RX_IDLE);

endmodule

// File: rtl/syn_rx_frame.sv
// Time-sync frame receiver: SYNC_BYTE, TIME_BYTES little-endian time bytes,
// XOR checksum; publishes the validated time word with a one-cycle strobe.
module syn_rx_frame
    import syn_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         TIME_BYTES   = 2,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         GAP_BITS     = 20
) (
    input  logic                    clk_10M,
    input  logic                    rst,
    input  logic                    data_to_slave,
    output logic [8*TIME_BYTES-1:0] syn_time,
    output logic                    syn_set,
    output logic                    load_ready,
    output logic                    frame_err,
    output logic                    rx_busy
);

    localparam int SW        = 8 * TIME_BYTES;
    localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
    localparam int GW        = $clog2(GAP_LIMIT + 1);

    logic [7:0] rx_data;
    logic       byte_valid;
    logic       byte_ferr;
    logic       rx_idle;

    syn_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_10M      (clk_10M),
        .rst          (rst),
        .data_to_slave(data_to_slave),
        .rx_data      (rx_data),
        .byte_valid   (byte_valid),
        .byte_ferr    (byte_ferr),
        .idle         (rx_idle)
    );

    fr_state_t     fstate_reg, fstate_next;
    logic [1:0]    idx_reg, idx_next;
    logic [7:0]    csum_reg, csum_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [SW-1:0] time_reg, time_next;
    logic          set_reg, set_next;
    logic          err_reg, err_next;
    logic          ready_reg, ready_next;
    logic          timeout;
    logic          load_lane;

    logic [7:0]    shadow_reg [TIME_BYTES];
    logic [SW-1:0] shadow_flat;

    assign load_lane = (fstate_reg == FR_TIME) && byte_valid;

    for (genvar gi = 0; gi < TIME_BYTES; gi++) begin : g_lane
        always_ff @(posedge clk_10M or posedge rst) begin
            if (rst) begin
                shadow_reg[gi] <= '0;
            end else if (load_lane && idx_reg == 2'(gi)) begin
                shadow_reg[gi] <= rx_data;
            end
        end
        assign shadow_flat[8*gi +: 8] = shadow_reg[gi];
    end

    always_ff @(posedge clk_10M or posedge rst) begin
        if (rst) begin
            fstate_reg <= FR_HUNT;
            idx_reg    <= '0;
            csum_reg   <= '0;
            gap_reg    <= '0;
            time_reg   <= '0;
            set_reg    <= 1'b0;
            err_reg    <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            fstate_reg <= fstate_next;
            idx_reg    <= idx_next;
            csum_reg   <= csum_next;
            gap_reg    <= gap_next;
            time_reg   <= time_next;
            set_reg    <= set_next;
            err_reg    <= err_next;
            ready_reg  <= ready_next;
        end
    end

    // gap_reg counts idle cycles since the last stop-bit sample; the
    // byte_valid cycle itself is already idle, hence the restart value of 1.
    assign timeout = (fstate_reg != FR_HUNT) && rx_idle && !byte_valid &&
                     (gap_reg == GW'(GAP_LIMIT - 1));

    always_comb begin
        fstate_next = fstate_reg;
        idx_next    = idx_reg;
        csum_next   = csum_reg;
        time_next   = time_reg;
        set_next    = 1'b0;
        err_next    = 1'b0;
        ready_next  = ready_reg;

        if (byte_valid) begin
            gap_next = GW'(1);
        end else if (fstate_reg == FR_HUNT) begin
            gap_next = '0;
        end else if (rx_idle) begin
            gap_next = gap_reg + 1'b1;
        end else begin
            gap_next = gap_reg;
        end

        case (fstate_reg)
            FR_HUNT: begin
                if (byte_valid && rx_data == SYNC_BYTE) begin
                    fstate_next = FR_TIME;
                    idx_next    = '0;
                    csum_next   = '0;
                end
            end
            FR_TIME: begin
                if (byte_valid) begin
                    csum_next = csum_reg ^ rx_data;
                    if (idx_reg == 2'(TIME_BYTES - 1)) begin
                        fstate_next = FR_CHECK;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else if (byte_ferr || timeout) begin
                    err_next    = 1'b1;
                    fstate_next = FR_HUNT;
                end
            end
            FR_CHECK: begin
                if (byte_valid) begin
                    if (rx_data == csum_reg) begin
                        time_next  = shadow_flat;
                        set_next   = 1'b1;
                        ready_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    fstate_next = FR_HUNT;
                end else if (byte_ferr || timeout) begin
                    err_next    = 1'b1;
                    fstate_next = FR_HUNT;
                end
            end
            default: fstate_next = FR_HUNT;
        endcase
    end

    assign syn_time   = time_reg;
    assign syn_set    = set_reg;
    assign frame_err  = err_reg;
    assign load_ready = ready_reg;
    assign rx_busy    = (fstate_reg != FR_HUNT);

endmodule
